// File: rtl/mips_mc_main_control_if.sv
// Control bundle between the multi-cycle MIPS main control FSM and the datapath.
// The controller drives the master side; the datapath/IR drives the slave side.
interface mips_mc_main_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IRWrite;
  logic [1:0] PCSource;
  logic [1:0] ALUOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       RegWrite;
  logic       RegDst;
  logic [3:0] state;
  logic       illegal_op;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, state, illegal_op
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, state, illegal_op
  );
endinterface

// File: rtl/mips_mc_main_control.sv
// Multi-cycle MIPS main control FSM: Moore-decoded datapath controls, with the
// FETCH commit strobes gated by mem_ready so a stalled fetch loads nothing.
module mips_mc_main_control (
  input  logic                          clk,
  input  logic                          rst,
  mips_mc_main_control_if.master        bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTYPE_EX = 4'd6,
    RTYPE_WB = 4'd7,
    BEQ      = 4'd8,
    JUMP     = 4'd9,
    ADDI_EX  = 4'd10,
    ADDI_WB  = 4'd11
  } state_t;

  state_t state_r;
  state_t state_nx;
  logic   illegal_r;
  logic   illegal_nx;

  // State and illegal-opcode flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= FETCH;
      illegal_r <= 1'b0;
    end else begin
      state_r   <= state_nx;
      illegal_r <= illegal_nx;
    end
  end

  // Next-state decode
  always_comb begin
    state_nx   = FETCH;
    illegal_nx = 1'b0;
    case (state_r)
      FETCH: begin
        if (bus.mem_ready) state_nx = DECODE;
        else               state_nx = FETCH;
      end
      DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_nx = MEMADR;
          OP_RTYPE:     state_nx = RTYPE_EX;
          OP_BEQ:       state_nx = BEQ;
          OP_J:         state_nx = JUMP;
          OP_ADDI:      state_nx = ADDI_EX;
          default: begin
            state_nx   = FETCH;
            illegal_nx = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        if (bus.opcode == OP_LW)      state_nx = MEMRD;
        else if (bus.opcode == OP_SW) state_nx = MEMWR;
        else                          state_nx = FETCH;
      end
      MEMRD: begin
        if (bus.mem_ready) state_nx = MEMWB;
        else               state_nx = MEMRD;
      end
      MEMWR: begin
        if (bus.mem_ready) state_nx = FETCH;
        else               state_nx = MEMWR;
      end
      RTYPE_EX: state_nx = RTYPE_WB;
      ADDI_EX:  state_nx = ADDI_WB;
      MEMWB, RTYPE_WB, ADDI_WB, BEQ, JUMP: state_nx = FETCH;
      // Codes 12-15 are not reachable; recover through FETCH.
      default:  state_nx = FETCH;
    endcase
  end

  // Moore output decode; fetch commits are also held off while in reset
  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.PCSource    = 2'b00;
    bus.ALUOp       = 2'b00;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.RegWrite    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.state       = state_r;
    bus.illegal_op  = illegal_r;
    case (state_r)
      FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.mem_ready & ~rst;
        bus.PCWrite = bus.mem_ready & ~rst;
      end
      DECODE:  bus.ALUSrcB = 2'b11;
      MEMADR, ADDI_EX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      MEMWB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
      end
      MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
      end
      RTYPE_EX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
      end
      RTYPE_WB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
      end
      BEQ: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = 2'b01;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
      end
      JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
      end
      ADDI_WB: bus.RegWrite = 1'b1;
      default: bus.PCWrite = 1'b0;
    endcase
  end

endmodule

// File: doc/mips_mc_main_control.md
Name: mips_mc_main_control

Overview:
- Multi-cycle MIPS main control FSM, directly upstream of the ALU control stage.
- Decodes Instruction[31:26] and steps fetch/decode/execute/memory/writeback.
- Drives all datapath enables and the 2-bit ALUOp consumed by ALU control.
- Outputs are Moore (decoded from the state register) except the FETCH commit gating described below, so ALUOp is stable across the whole cycle, including the falling edge.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word
- OP_SW, 6'b101011, store word
- OP_BEQ, 6'b000100, branch equal
- OP_J, 6'b000010, jump
- OP_ADDI, 6'b001000, add immediate

Ports:
- clk  in  1  system clock; rising-edge state update
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  Instruction[31:26] from IR, valid from DECODE onward
- mem_ready  in  1  memory handshake: access completes in the cycle it is high
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU zero
- IorD  out  1  0 = PC address, 1 = ALUOut address
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- MemtoReg  out  1  register write-data select: 1 = MDR
- IRWrite  out  1  instruction register load
- PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct-decoded
- ALUSrcA  out  1  0 = PC, 1 = rs
- ALUSrcB  out  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = shifted imm
- RegWrite  out  1  register file write
- RegDst  out  1  0 = rt, 1 = rd
- state  out  4  current state encoding, for debug
- illegal_op  out  1  one-cycle flag on an unknown opcode

Behaviour:
- State encoding: FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, RTYPE_EX = 6, RTYPE_WB = 7, BEQ = 8, JUMP = 9, ADDI_EX = 10, ADDI_WB = 11.
- Codes 12–15 are unreachable; if entered, go to FETCH next cycle.
- Reset: rst = 1 asynchronously forces state = FETCH and illegal_op = 0. All other outputs then take their FETCH values.

Transitions:
- FETCH: go to DECODE if mem_ready, else hold.
- DECODE, by opcode:
  - LW or SW → MEMADR
  - RTYPE → RTYPE_EX
  - BEQ → BEQ
  - J → JUMP
  - ADDI → ADDI_EX
  - any other opcode → FETCH, with illegal_op registered high for exactly the next cycle.
- MEMADR: LW → MEMRD, SW → MEMWR. The opcode is re-sampled here; the IR is stable.
- MEMRD: go to MEMWB if mem_ready, else hold.
- MEMWR: go to FETCH if mem_ready, else hold.
- MEMWB, RTYPE_WB, ADDI_WB, BEQ, JUMP: go to FETCH.
- RTYPE_EX → RTYPE_WB; ADDI_EX → ADDI_WB.

Outputs (all unlisted signals are 0):
- FETCH: MemRead = 1, ALUSrcB = 01, ALUOp = 00, PCSource = 00. IRWrite = PCWrite = mem_ready, so nothing commits while stalled.
- DECODE: ALUSrcB = 11, ALUOp = 00.
- MEMADR and ADDI_EX: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00.
- MEMRD: MemRead = 1, IorD = 1.
- MEMWB: RegWrite = 1, MemtoReg = 1.
- MEMWR: MemWrite = 1, IorD = 1.
- RTYPE_EX: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10.
- RTYPE_WB: RegWrite = 1, RegDst = 1.
- BEQ: ALUSrcA = 1, ALUOp = 01, PCWriteCond = 1, PCSource = 01.
- JUMP: PCWrite = 1, PCSource = 10.
- ADDI_WB: RegWrite = 1.

Invariants and boundaries:
- Latency with mem_ready held high: lw 5 cycles, sw/R/addi 4, beq/j 3. Each mem_ready = 0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- MemRead and MemWrite are never both 1.
- RegWrite is never 1 outside the WB states.
- Reset mid-instruction aborts it; no write strobe may be asserted while rst = 1.
- opcode changes outside DECODE and MEMADR are ignored.

Test Plan:
- Reset → assert rst mid-MEMWR, async → state = 0 and MemWrite = 0 immediately, before the next edge; illegal_op = 0.
- lw, mem_ready = 1 → states 0,1,2,3,4,0; ALUOp sequence 00,00,00,00,00; RegWrite = 1 only in state 4 with MemtoReg = 1.
- R-type → states 0,1,6,7,0; ALUOp = 10 in state 6; RegDst = RegWrite = 1 in state 7.
- beq, then j → beq: state 8 with ALUOp = 01, PCWriteCond = 1, PCSource = 01. j: state 9 with PCWrite = 1, PCSource = 10. Both return to FETCH.
- Stalls → FETCH with mem_ready = 0 for 3 cycles: state holds at 0 and IRWrite = PCWrite = 0 throughout. sw with MEMWR stalled 2 cycles: MemWrite = 1 for 3 cycles, then FETCH.
- Illegal opcode 6'b111111 → DECODE → FETCH; illegal_op = 1 for one cycle; no RegWrite or MemWrite asserted.
